// File: rtl/oram_pkg.sv
// Shared types and width helpers for the ORAM Avalon bridge.
package oram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StResp
    } oram_bridge_state_t;

    // Address bits consumed by an n-way split; zero when there is nothing to select.
    function automatic int unsigned split_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // A select field needs at least one bit even when it is unused.
    function automatic int unsigned field_width(input int unsigned bits);
        return (bits > 0) ? bits : 1;
    endfunction

    localparam int unsigned OramWordW  = 32;
    localparam int unsigned OramBlockW = 4 * OramWordW;

    typedef logic [OramWordW-1:0]  oram_word_t;
    typedef logic [OramBlockW-1:0] oram_block_t;

endpackage

// File: rtl/oram_block_merge.sv
// Combinational byte-lane merge of one Avalon word into a multi-word ORAM block.
module oram_block_merge #(
    parameter int unsigned BYTE_WIDTH      = 8,
    parameter int unsigned BYTES_PER_WORD  = 4,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned SEL_WIDTH       = 2
) (
    input  logic [BYTES_PER_WORD*WORDS_PER_BLOCK*BYTE_WIDTH-1:0] block_in,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0]                 word,
    input  logic [BYTES_PER_WORD-1:0]                            byteenable,
    input  logic [SEL_WIDTH-1:0]                                 word_sel,
    output logic [BYTES_PER_WORD*WORDS_PER_BLOCK*BYTE_WIDTH-1:0] block_out
);

    always_comb begin
        block_out = block_in;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (word_sel == SEL_WIDTH'(w) && byteenable[b]) begin
                    block_out[(w*BYTES_PER_WORD+b)*BYTE_WIDTH +: BYTE_WIDTH] =
                        word[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/oram_block_bridge.sv
// Avalon-MM slave front-end doing block-wide read-modify-write over the ORAM core handshake.
// Optional one-entry block cache when ORAM_BLOCK_CACHE_EN is defined.
module oram_block_bridge
    import oram_pkg::*;
#(
    parameter int unsigned BYTE_WIDTH      = 8,
    parameter int unsigned BYTES_PER_WORD  = 4,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned BYTES_PER_BLOCK = BYTES_PER_WORD * WORDS_PER_BLOCK,
    parameter int unsigned ADDRESS_WIDTH   = 8,
    parameter int unsigned MEMORY_SIZE     = 1 << ADDRESS_WIDTH,
    parameter int unsigned TREE_DEPTH      = $clog2(MEMORY_SIZE / BYTES_PER_BLOCK)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [ADDRESS_WIDTH-1:0]             avs_a_address,
    input  logic [BYTES_PER_WORD-1:0]            avs_a_byteenable,
    input  logic                                 avs_a_read,
    input  logic                                 avs_a_write,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_a_writedata,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_a_readdata,
    output logic                                 avs_a_waitrequest,
    output logic                                 avs_a_readdatavalid,
    output logic [TREE_DEPTH-1:0]                rw_block_number,
    output logic [BYTES_PER_BLOCK*BYTE_WIDTH-1:0] w_value,
    output logic                                 rw_indicator,
    output logic                                 input_ready,
    input  logic [BYTES_PER_BLOCK*BYTE_WIDTH-1:0] r_value,
    input  logic                                 output_ready
);

    localparam int unsigned WordW    = BYTES_PER_WORD * BYTE_WIDTH;
    localparam int unsigned BlockW   = BYTES_PER_BLOCK * BYTE_WIDTH;
    localparam int unsigned ByteBits = split_bits(BYTES_PER_WORD);
    localparam int unsigned SelBits  = split_bits(WORDS_PER_BLOCK);
    localparam int unsigned SelW     = field_width(SelBits);

    oram_bridge_state_t      state_q, state_d;
    logic [TREE_DEPTH-1:0]   blk_q;
    logic [SelW-1:0]         sel_q;
    logic [BYTES_PER_WORD-1:0] be_q;
    logic [WordW-1:0]        wdata_q, rdata_q;
    logic                    is_write_q, rw_ind_q;
    logic [BlockW-1:0]       block_q;

    logic [TREE_DEPTH-1:0]   in_blk;
    logic [SelW-1:0]         in_sel;
    logic                    read_hit, write_hit, direct_wr;
    logic [BlockW-1:0]       hit_data, merge_base, merged, rd_src;
    logic [WordW-1:0]        merge_word, rd_word;
    logic [BYTES_PER_WORD-1:0] merge_be;
    logic [SelW-1:0]         merge_sel;
    logic                    idle;

    assign in_blk = avs_a_address[ADDRESS_WIDTH-1 -: TREE_DEPTH];

    if (SelBits > 0) begin : g_sel
        assign in_sel = avs_a_address[ByteBits +: SelW];
    end else begin : g_nosel
        assign in_sel = '0;
    end

    if (ByteBits > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^avs_a_address[ByteBits-1:0];
    end

`ifdef ORAM_BLOCK_CACHE_EN
    logic                  cache_valid_q;
    logic [TREE_DEPTH-1:0] cache_blk_q;
    logic [BlockW-1:0]     cache_data_q;

    assign read_hit  = cache_valid_q && (cache_blk_q == in_blk);
    assign write_hit = read_hit;
    assign hit_data  = write_hit ? cache_data_q : block_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cache_valid_q <= 1'b0;
            cache_blk_q   <= '0;
            cache_data_q  <= '0;
        end else if (state_q == StRdWait && output_ready) begin
            cache_valid_q <= 1'b1;
            cache_blk_q   <= blk_q;
            cache_data_q  <= r_value;
        end else if (state_q == StWrReq) begin
            cache_valid_q <= 1'b1;
            cache_blk_q   <= blk_q;
            cache_data_q  <= block_q;
        end
    end
`else
    assign read_hit  = 1'b0;
    assign write_hit = 1'b0;
    assign hit_data  = block_q;
`endif

    assign idle      = (state_q == StIdle);
    // Full-word write to a single-word block needs no old data to merge with.
    assign direct_wr = ((WORDS_PER_BLOCK == 1) && (&avs_a_byteenable)) || write_hit;

    assign merge_base = (state_q == StRdWait) ? r_value : hit_data;
    assign merge_word = idle ? avs_a_writedata : wdata_q;
    assign merge_be   = idle ? avs_a_byteenable : be_q;
    assign merge_sel  = idle ? in_sel : sel_q;
    assign rd_src     = idle ? hit_data : r_value;

    oram_block_merge #(
        .BYTE_WIDTH      (BYTE_WIDTH),
        .BYTES_PER_WORD  (BYTES_PER_WORD),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .SEL_WIDTH       (SelW)
    ) u_merge (
        .block_in   (merge_base),
        .word       (merge_word),
        .byteenable (merge_be),
        .word_sel   (merge_sel),
        .block_out  (merged)
    );

    always_comb begin
        rd_word = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            if (merge_sel == SelW'(w)) rd_word = rd_src[w*WordW +: WordW];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (avs_a_write)     state_d = direct_wr ? StWrReq : StRdReq;
                else if (avs_a_read) state_d = read_hit ? StResp : StRdReq;
            end
            StRdReq:  state_d = StRdWait;
            StRdWait: if (output_ready) state_d = is_write_q ? StWrReq : StResp;
            StWrReq:  state_d = StWrWait;
            StWrWait: if (output_ready) state_d = StIdle;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            sel_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            rw_ind_q   <= 1'b0;
            block_q    <= '0;
        end else begin
            state_q  <= state_d;
            rw_ind_q <= (state_d == StWrReq);
            if (idle && (avs_a_read || avs_a_write)) begin
                blk_q      <= in_blk;
                sel_q      <= in_sel;
                be_q       <= avs_a_byteenable;
                wdata_q    <= avs_a_writedata;
                is_write_q <= avs_a_write;
                if (avs_a_write && direct_wr) block_q <= merged;
                if (!avs_a_write && read_hit) rdata_q <= rd_word;
            end
            if (state_q == StRdWait && output_ready) begin
                if (is_write_q) block_q <= merged;
                else            rdata_q <= rd_word;
            end
        end
    end

    assign avs_a_waitrequest   = !idle;
    assign avs_a_readdatavalid = (state_q == StResp);
    assign avs_a_readdata      = rdata_q;
    assign input_ready         = (state_q == StRdReq) || (state_q == StWrReq);
    assign rw_indicator        = rw_ind_q;
    assign rw_block_number     = blk_q;
    assign w_value             = block_q;

endmodule

// File: tb/tb_oram_block_bridge.sv
// Directed self-checking bench for oram_block_bridge (default build, cache disabled).
module tb_oram_block_bridge;
    import oram_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  avs_a_address;
    logic [3:0]  avs_a_byteenable;
    logic        avs_a_read, avs_a_write;
    oram_word_t  avs_a_writedata, avs_a_readdata;
    logic        avs_a_waitrequest, avs_a_readdatavalid;
    logic [3:0]  rw_block_number;
    oram_block_t w_value, r_value;
    logic        rw_indicator, input_ready, output_ready;

    int n_total = 0;
    int n_bad   = 0;
    int ir_cnt  = 0;
    int rdv_cnt = 0;
    int ir0, rdv0;

    oram_block_bridge dut (
        .clock               (clock),
        .reset               (reset),
        .avs_a_address       (avs_a_address),
        .avs_a_byteenable    (avs_a_byteenable),
        .avs_a_read          (avs_a_read),
        .avs_a_write         (avs_a_write),
        .avs_a_writedata     (avs_a_writedata),
        .avs_a_readdata      (avs_a_readdata),
        .avs_a_waitrequest   (avs_a_waitrequest),
        .avs_a_readdatavalid (avs_a_readdatavalid),
        .rw_block_number     (rw_block_number),
        .w_value             (w_value),
        .rw_indicator        (rw_indicator),
        .input_ready         (input_ready),
        .r_value             (r_value),
        .output_ready        (output_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (input_ready)         ir_cnt++;
        if (avs_a_readdatavalid) rdv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic avs_access(input logic [7:0] addr, input logic [3:0] be, input logic rd,
                              input logic wr, input oram_word_t data);
        @(posedge clock);
        #1;
        avs_a_address    = addr;
        avs_a_byteenable = be;
        avs_a_read       = rd;
        avs_a_write      = wr;
        avs_a_writedata  = data;
        @(negedge clock);
        check_eq("accept_waitreq", avs_a_waitrequest, 1'b0);
        @(posedge clock);
        #1;
        avs_a_read  = 1'b0;
        avs_a_write = 1'b0;
    endtask

    // Waits for a core request, checks it, then answers after lat idle cycles.
    task automatic core_serve(input logic exp_rw, input logic [3:0] exp_blk, input oram_block_t rdata,
                              input logic chk_wval, input oram_block_t exp_wval, input int lat);
        int n = 0;
        @(negedge clock);
        while (!input_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("core_req_seen", input_ready, 1'b1);
        check_eq("core_rw_ind", rw_indicator, exp_rw);
        check_eq("core_blk", rw_block_number, exp_blk);
        if (chk_wval) check_eq("core_w_value", w_value, exp_wval);
        @(negedge clock);
        check_eq("core_req_one_cycle", input_ready, 1'b0);
        repeat (lat) @(negedge clock);
        output_ready = 1'b1;
        r_value      = rdata;
        @(posedge clock);
        #1;
        output_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        avs_a_address    = '0;
        avs_a_byteenable = '0;
        avs_a_read       = 1'b0;
        avs_a_write      = 1'b0;
        avs_a_writedata  = '0;
        r_value          = '0;
        output_ready     = 1'b0;

        repeat (2) @(negedge clock);
        check_eq("rst_waitreq", avs_a_waitrequest, 1'b0);
        check_eq("rst_input_ready", input_ready, 1'b0);
        check_eq("rst_rdv", avs_a_readdatavalid, 1'b0);
        check_eq("rst_readdata", avs_a_readdata, 32'h0);
        check_eq("rst_w_value", w_value, 128'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("idle_no_core_req", ir_cnt, 0);

        // Read block 1 word 1.
        ir0 = ir_cnt; rdv0 = rdv_cnt;
        avs_access(8'h14, 4'hF, 1'b1, 1'b0, 32'h0);
        core_serve(1'b0, 4'd1, {32'h0, 32'h0, 32'hAAAA5555, 32'h0}, 1'b0, '0, 0);
        @(negedge clock);
        check_eq("rd_valid", avs_a_readdatavalid, 1'b1);
        check_eq("rd_data", avs_a_readdata, 32'hAAAA5555);
        @(negedge clock);
        check_eq("rd_valid_pulse", avs_a_readdatavalid, 1'b0);
        check_eq("rd_core_reqs", ir_cnt - ir0, 1);
        check_eq("rd_rdv_count", rdv_cnt - rdv0, 1);

        // Partial write to block 2 word 1: read-modify-write.
        ir0 = ir_cnt; rdv0 = rdv_cnt;
        avs_access(8'h24, 4'b0011, 1'b0, 1'b1, 32'h12345678);
        core_serve(1'b0, 4'd2, {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111},
                   1'b0, '0, 1);
        core_serve(1'b1, 4'd2, '0, 1'b1,
                   {32'h33333333, 32'h22222222, 32'hDEAD5678, 32'h11111111}, 2);
        repeat (2) @(negedge clock);
        check_eq("wr_idle", avs_a_waitrequest, 1'b0);
        check_eq("wr_core_reqs", ir_cnt - ir0, 2);
        check_eq("wr_no_rdv", rdv_cnt - rdv0, 0);
        check_eq("rd_data_held", avs_a_readdata, 32'hAAAA5555);

        // Read and write together: write wins.
        ir0 = ir_cnt; rdv0 = rdv_cnt;
        avs_access(8'h00, 4'hF, 1'b1, 1'b1, 32'hCAFEF00D);
        core_serve(1'b0, 4'd0, {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777},
                   1'b0, '0, 0);
        core_serve(1'b1, 4'd0, '0, 1'b1,
                   {32'h44444444, 32'h55555555, 32'h66666666, 32'hCAFEF00D}, 0);
        repeat (3) @(negedge clock);
        check_eq("rw_core_reqs", ir_cnt - ir0, 2);
        check_eq("rw_no_rdv", rdv_cnt - rdv0, 0);

        // byteenable=0 still does both accesses and writes the old block back.
        ir0 = ir_cnt;
        avs_access(8'h3C, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFFF);
        core_serve(1'b0, 4'd3, {32'h89ABCDEF, 32'h01234567, 32'hFEDCBA98, 32'h76543210},
                   1'b0, '0, 0);
        core_serve(1'b1, 4'd3, '0, 1'b1,
                   {32'h89ABCDEF, 32'h01234567, 32'hFEDCBA98, 32'h76543210}, 0);
        repeat (2) @(negedge clock);
        check_eq("be0_core_reqs", ir_cnt - ir0, 2);

        // Stale output_ready while idle is ignored.
        ir0 = ir_cnt; rdv0 = rdv_cnt;
        output_ready = 1'b1;
        @(posedge clock);
        #1 output_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("idle_ordy_waitreq", avs_a_waitrequest, 1'b0);
        check_eq("idle_ordy_rdv", rdv_cnt - rdv0, 0);
        check_eq("idle_ordy_reqs", ir_cnt - ir0, 0);

        // Reset while waiting on the core.
        ir0 = ir_cnt; rdv0 = rdv_cnt;
        avs_access(8'h40, 4'hF, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        check_eq("mid_req", input_ready, 1'b1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_waitreq", avs_a_waitrequest, 1'b0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        output_ready = 1'b1;
        r_value      = {4{32'h5A5A5A5A}};
        @(posedge clock);
        #1 output_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("mid_no_rdv", rdv_cnt - rdv0, 0);
        check_eq("mid_waitreq", avs_a_waitrequest, 1'b0);
        check_eq("mid_reqs", ir_cnt - ir0, 1);
        check_eq("mid_readdata_clr", avs_a_readdata, 32'h0);

        // Top block, word 2, after recovery.
        rdv0 = rdv_cnt;
        avs_access(8'hF8, 4'hF, 1'b1, 1'b0, 32'h0);
        core_serve(1'b0, 4'd15, {32'h0, 32'h0BADC0DE, 32'h1, 32'h2}, 1'b0, '0, 2);
        @(negedge clock);
        check_eq("top_rd_valid", avs_a_readdatavalid, 1'b1);
        check_eq("top_rd_data", avs_a_readdata, 32'h0BADC0DE);
        @(negedge clock);
        check_eq("top_rdv_count", rdv_cnt - rdv0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
